uart_word_tx: RTL and testbench
===============================

// Module: uart_word_tx
// PURPOSE
//  Multi-byte UART transmitter: accepts one DATA_BYTES-wide word per valid/ready handshake, serializes it as 8N1 frames on txd.
//  Bytes go out least-significant byte first, bits LSB first. Mirror of the uart receive path; sits next to uart, drives the board TX pin.
// PARAMETERS
//  CLKS_PER_BIT  15  clk cycles per UART bit (>=2); 15 matches the 150 ns bit time at the 10 ns clk
//  DATA_BYTES     4  bytes per accepted word (>=1)
// PORTS
//  clk       in   1               system clock; the only clock, all logic on posedge
//  rst       in   1               synchronous, active-high reset
//  tx_data   in   8*DATA_BYTES    word to send; byte0 = tx_data[7:0]
//  tx_valid  in   1               word present
//  tx_ready  out  1               block idle, will accept word this cycle
//  txd       out  1               serial line, idle high
//  tx_busy   out  1               frame sequence in progress
//  tx_done   out  1               1-cycle pulse: last stop bit of the word finished
// BEHAVIOUR
//  - Reset (rst=1 at posedge): txd=1, tx_ready=0, tx_busy=0, tx_done=0, state=IDLE, all counters 0. tx_ready=1 from the first cycle after rst falls.
//  - All outputs registered. Word latched into shift reg on tx_valid&tx_ready (cycle N); txd=0 (start) from N+1; tx_ready=0, tx_busy=1 from N+1.
//  - FSM: IDLE -> START -> DATA(8 bits) -> [PARITY] -> STOP -> START of next byte, or IDLE after byte DATA_BYTES-1.
//  - Each bit held exactly CLKS_PER_BIT cycles; baud counter 0..CLKS_PER_BIT-1, restarts at every bit boundary, no drift.
//  - Bit idx 0..7, byte idx 0..DATA_BYTES-1; both wrap to 0 on word end. Counter widths $clog2-sized, no overflow.
//  - Back-to-back bytes within a word: stop bit followed immediately by next start bit, no idle gap.
//  - Word end: cycle after last stop bit expires -> state=IDLE, tx_done=1 (one cycle), tx_ready=1, tx_busy=0, txd=1.
//  - tx_valid held high continuously: next word accepted in that IDLE cycle -> exactly one idle-high clk between words.
//  - tx_valid while busy: ignored, tx_data not sampled; no queuing.
//  - Total word time without parity: DATA_BYTES*10*CLKS_PER_BIT cycles (600 at defaults) from start bit to IDLE.
//  - rst mid-frame: word discarded, txd=1 on next edge, no tx_done pulse.
// CONFIGURATION
//  UART_PARITY_EN defined: PARITY state inserted after bit 7; txd = even parity (XOR of the 8 data bits), held CLKS_PER_BIT cycles.
//   Frame 8E1, 11 bits; word time DATA_BYTES*11*CLKS_PER_BIT.
//  UART_PARITY_EN undefined: no PARITY state or logic; 8N1 frame, 10 bits.
// STRUCTURE
//  - Package uart_pkg: tx state enum (IDLE, START, DATA, PARITY, STOP), UART_DATA_BITS=8, start/stop/idle level constants; shared with receive path.
//  - Sub-module uart_baud_tick: counter, CLKS_PER_BIT param, clear input, 1-cycle bit_end pulse; FSM in uart_word_tx.
// TESTING
//  - Reset: hold rst 3 cycles, tx_valid=1 -> txd=1, tx_ready=0, no accept; tx_ready=1 the cycle after rst falls.
//  - Single word: tx_data=32'h454b4f43, 1-cycle valid -> txd bytes 0x43,0x4F,0x4B,0x45, each 0,LSB..MSB,1, 15 clk/bit; tx_done at +601 cycles.
//  - Bit timing: check every txd transition on a multiple of 15 cycles from start bit; no glitch at byte boundaries.
//  - Back-to-back: tx_valid held, words 32'h00000000 then 32'hFFFFFFFF -> exactly one idle cycle between words, second word bit-exact.
//  - Busy-ignore/reset: change tx_data and pulse tx_valid mid-frame -> no effect; assert rst in byte 2 -> txd=1 next cycle, no tx_done.
//  - UART_PARITY_EN build: 8'h31 bytes (32'h31313131) -> parity bit 1 after each byte, tx_done at +661 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Holds the frame constants, the tx FSM state encodings and a helper
// that gives a safe index width for small counts.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Line levels
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;
    localparam logic UART_IDLE_LEVEL  = 1'b1;

    // Transmit FSM state encodings
    typedef logic [2:0] tx_state_t;
    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    // Width of an index able to hold 0..n-1, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each
// bit period with bit_end_o. clear_i holds the count at zero so the first
// bit after a clear is a full period long.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int CW = idx_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at the bit boundary so every bit is exactly one period
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = !clear_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_word_tx.sv
// Multi-byte UART transmitter.
// Accepts one DATA_BYTES-wide word per valid/ready handshake and sends it
// LSB byte first, each byte LSB bit first, as back-to-back serial frames.
// Build option: define UART_PARITY_EN to insert an even parity bit after
// the eight data bits (8E1); leave it undefined for plain 8N1 frames.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 15,
    parameter int DATA_BYTES   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [8*DATA_BYTES-1:0]       tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic                          tx_done
);

    localparam int WORD_W = UART_DATA_BITS * DATA_BYTES;
    localparam int BIT_W  = idx_width(UART_DATA_BITS);
    localparam int BYTE_W = idx_width(DATA_BYTES);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(DATA_BYTES - 1);

    tx_state_t         state_q,    state_d;
    logic [WORD_W-1:0] shift_q,    shift_d;
    logic [BIT_W-1:0]  bit_idx_q,  bit_idx_d;
    logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
    logic              txd_q,      txd_d;
    logic              ready_q,    ready_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
`ifdef UART_PARITY_EN
    logic              parity_q,   parity_d;
`endif

    logic bit_end;
    logic accept;

    // The timer idles at zero so the start bit gets a full period
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == ST_IDLE),
        .bit_end_o (bit_end)
    );

    // ready_q is only ever high in IDLE, so busy-time valids are ignored
    assign accept = ready_q && tx_valid;

    // Frame sequencing: next state and next value of every registered output
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        txd_d      = txd_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                txd_d   = UART_IDLE_LEVEL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (accept) begin
                    shift_d    = tx_data;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    txd_d      = UART_START_LEVEL;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    txd_d     = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
`ifdef UART_PARITY_EN
                    parity_d  = ^shift_q[UART_DATA_BITS-1:0];
`endif
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    // Shifting once per bit leaves the next byte in [7:0]
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
`ifdef UART_PARITY_EN
                        txd_d     = parity_q;
                        state_d   = ST_PARITY;
`else
                        txd_d     = UART_STOP_LEVEL;
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    txd_d   = UART_STOP_LEVEL;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d = '0;
                        txd_d      = UART_IDLE_LEVEL;
                        ready_d    = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        // Next start bit follows the stop bit with no gap
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                        txd_d      = UART_START_LEVEL;
                        state_d    = ST_START;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                bit_idx_d  = '0;
                byte_idx_d = '0;
                txd_d      = UART_IDLE_LEVEL;
                ready_d    = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            txd_q      <= UART_IDLE_LEVEL;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_ready = ready_q;
    assign txd      = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx at default parameters.
// A serial monitor decodes txd frames and compares bytes against a
// scoreboard queue filled by the driver; the driver checks handshake,
// latency and reset behaviour. Honours UART_PARITY_EN.
module tb_uart_word_tx;

    localparam int CLKS   = 15;
    localparam int NBYTES = 4;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_LAT = NBYTES * FRAME_BITS * CLKS + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tx_data = 32'h0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        txd;
    logic        tx_busy;
    logic        tx_done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_frames = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] data;
        logic        exp_bit0;
        int          exp_lat;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    uart_word_tx #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BYTES   (NBYTES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < NBYTES; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    // Handshake one word; returns at the first cycle after acceptance
    task automatic start_word(input logic [31:0] w, input bit hold);
        int k = 0;
        while (tx_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_word", tx_ready, 1);
        tx_data  = w;
        tx_valid = 1'b1;
        push_word(w);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
        check("txd_start_bit", txd, 0);
        check("busy_after_accept", tx_busy, 1);
        check("ready_after_accept", tx_ready, 0);
    endtask

    // Counts cycles since acceptance until tx_done, bounded
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (tx_done !== 1'b1 && lat < WORD_LAT + 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Serial monitor: every bit must hold one level for exactly CLKS cycles
    initial begin : monitor
        logic [7:0] rx;
        logic       lvl;
        logic       ok;
        logic       par;
        bit         aborted;
        lvl = 1'b1;
        par = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                aborted = 1'b0;
                ok      = 1'b1;
                rx      = 8'h00;
                for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
                    for (int c = 0; c < CLKS; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) lvl = txd;
                        else if (txd !== lvl) ok = 1'b0;
                    end
                    if (!aborted) begin
                        if (b >= 1 && b <= 8) rx[b-1] = lvl;
                        if (b == 9) par = lvl;
                        if (b == FRAME_BITS - 1 && lvl !== 1'b1) ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    logic [7:0] e;
                    n_frames++;
                    check("frame_timing_and_stop", {31'b0, ok}, 1);
                    check("frame_was_expected", {31'b0, exp_q.size() != 0}, 1);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    check("frame_byte", rx, e);
`ifdef UART_PARITY_EN
                    check("frame_parity", {31'b0, par}, {31'b0, ^e});
`endif
                    $display("frame %0d: byte %02h expected %02h", n_frames, rx, e);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int lat;
        int dones;
        vecs[0] = '{32'h454b4f43, 1'b1, WORD_LAT};
        vecs[1] = '{32'hA5C30F80, 1'b0, WORD_LAT};
        vecs[2] = '{32'h31313131, 1'b1, WORD_LAT};
        vecs[3] = '{32'h00000001, 1'b1, WORD_LAT};
        vecs[4] = '{32'h80000000, 1'b0, WORD_LAT};

        // Reset held three cycles with valid high: nothing accepted
        tx_valid = 1'b1;
        tx_data  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_txd", txd, 1);
            check("rst_ready", tx_ready, 0);
            check("rst_busy", tx_busy, 0);
            check("rst_done", tx_done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1);
        tx_valid = 1'b0;
        @(negedge clk);
        check("no_accept_in_rst_txd", txd, 1);
        check("no_accept_in_rst_busy", tx_busy, 0);
        $display("reset sequence done");

        // Table of single words
        for (int i = 0; i < 5; i++) begin
            start_word(vecs[i].data, 1'b0);
            repeat (CLKS) @(negedge clk);
            check("first_data_bit", txd, {31'b0, vecs[i].exp_bit0});
            wait_done(CLKS + 1, lat);
            check("done_latency", lat, vecs[i].exp_lat);
            check("done_txd_idle", txd, 1);
            check("done_ready", tx_ready, 1);
            check("done_busy", tx_busy, 0);
            check("all_bytes_seen", exp_q.size(), 0);
            @(negedge clk);
            check("done_one_cycle", tx_done, 0);
            $display("word %08h: done after %0d cycles", vecs[i].data, lat);
        end

        // Back-to-back with valid held: one idle cycle between words
        start_word(32'h00000000, 1'b1);
        tx_data = 32'hFFFFFFFF;
        push_word(32'hFFFFFFFF);
        wait_done(1, lat);
        check("b2b_first_latency", lat, WORD_LAT);
        check("b2b_idle_txd", txd, 1);
        check("b2b_idle_ready", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("b2b_second_start", txd, 0);
        check("b2b_second_busy", tx_busy, 1);
        wait_done(1, lat);
        check("b2b_second_latency", lat, WORD_LAT);
        check("b2b_all_bytes_seen", exp_q.size(), 0);
        $display("back-to-back words done");

        // Valid and data changes while busy are ignored
        @(negedge clk);
        start_word(32'h12345678, 1'b0);
        repeat (99) @(negedge clk);
        tx_data  = 32'hFFFF0000;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done(101, lat);
        check("busy_ignore_latency", lat, WORD_LAT);
        repeat (40) @(negedge clk);
        check("busy_ignore_no_queue_busy", tx_busy, 0);
        check("busy_ignore_no_queue_txd", txd, 1);
        check("busy_ignore_bytes_seen", exp_q.size(), 0);
        $display("busy-ignore word done");

        // Reset in the middle of byte 2
        start_word(32'hCAFEF00D, 1'b0);
        repeat (349) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_txd", txd, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_ready", tx_ready, 0);
        check("midrst_done", tx_done, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) dones++;
        end
        check("midrst_no_done_pulse", dones, 0);
        check("midrst_ready_again", tx_ready, 1);
        check("midrst_txd_idle", txd, 1);
        $display("mid-frame reset done");

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
